deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Serial-to-parallel front end that sits directly upstream of the 8-entry byte queue.
- Samples one serial bit per clock_10 cycle when write_in is high and assembles bytes MSB-first.
- Pushes each completed byte into the queue with a single-cycle enqueue pulse, and stalls while the queue reports full.
- Exposes a ready status to the serial source and a saturating count of bits dropped during stalls.

Parameters:
- WIDTH, 8, bits per assembled word; equals the queue data width.
- DEPTH, 8, queue capacity; queue_len_in == DEPTH means the queue is full.
- LEN_W, 4, width of queue_len_in; must hold values 0..DEPTH.

Ports:
- clock_10  in  1  system clock, 10 kHz, all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- data_in  in  1  serial bit, sampled only when write_in = 1.
- write_in  in  1  bit-valid strobe, level-sampled each edge.
- queue_len_in  in  LEN_W  queue occupancy, wired from the queue's len_out.
- data_out  out  WIDTH  assembled byte, wired to the queue's data_in.
- enq_out  out  1  one-cycle enqueue pulse, wired to the queue's enq_in.
- status_out  out  1  1 = accepting bits (state RECEIVE); 0 = stalled/pushing.
- drop_cnt_out  out  8  saturating count of write_in strobes ignored while status_out = 0.

Behaviour:
- Reset is async, active-high, and forces all of the following immediately:
  - state = RECEIVE; shift register = 0; bit_cnt = 0.
  - data_out = 0; enq_out = 0; status_out = 1; drop_cnt_out = 0.
- Reset mid-byte or mid-stall discards the partial or pending byte. No enq_out pulse is emitted after reset.
- All outputs are registered.
- States:
  - RECEIVE: on an edge with write_in = 1, shift {shift[WIDTH-2:0], data_in} and increment bit_cnt.
    - When the WIDTH-th bit is sampled: data_out <= completed byte (including that bit); bit_cnt <= 0; state <= PUSH; status_out <= 0.
    - write_in = 0: hold; no timeout, so a partial byte persists indefinitely.
  - PUSH: if queue_len_in < DEPTH: enq_out <= 1; state <= RECEIVE; status_out <= 1.
    - Otherwise remain in PUSH, keeping enq_out = 0 and data_out stable.
- enq_out is high for exactly one clock period per byte, and deasserts on the following edge unconditionally.
- Latency from 8th bit sampled at edge E:
  - data_out valid after E.
  - enq_out high in cycle E+1..E+2 when the queue is not full.
  - The queue captures at E+2.
- data_out is held unchanged from byte completion until the next byte completes, so it is stable during enq_out.
- Bits arriving while enq_out is high: state is already RECEIVE, so they are accepted normally.
- write_in = 1 while in PUSH: the bit is ignored; drop_cnt_out increments and saturates at 255.
- Queue full (queue_len_in == DEPTH) in PUSH: stall until occupancy falls, then push on the first edge it is < DEPTH.
- queue_len_in > DEPTH (illegal): treated as full.
- Bit order: the first bit received lands in data_out[WIDTH-1].

Decomposition:
- Package deser_pkg holds:
  - typedef enum logic [0:0] {RECEIVE, PUSH} deser_state_t.
  - Constants WIDTH_DEF = 8, DEPTH_DEF = 8, DROP_MAX = 8'hFF.
- Single flat module; no sub-module. The shift register and counter are too small to justify one.

Test Plan:
- Reset; then with queue_len_in = 0, send bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> data_out = 8'hA5 after the 8th edge; enq_out high for exactly one cycle one edge later; status_out goes 0 for exactly one cycle.
- Send 8'h3C with write_in gapped (bit, idle, bit, ...) -> same result as contiguous; bit_cnt holds during gaps; data_out = 8'h3C.
- Hold queue_len_in = 8 and complete 8'hFF, then pulse write_in 3 times -> no enq_out; status_out = 0; drop_cnt_out = 3; data_out = 8'hFF stable. Drop queue_len_in to 7 -> enq_out pulses on the next edge; status_out returns to 1.
- Connect to the queue and stream 9 bytes 8'h01..8'h09 back-to-back with no dequeue -> 8 bytes enqueued; 9th byte stalls in PUSH. A single dequeue returns 8'h01, then 8'h09 is enqueued.
- Assert reset after 5 bits of a byte and also while stalled in PUSH -> all outputs return to reset values at once; a subsequent full byte 8'h5A is assembled correctly with no stray enq_out.
- Stall in PUSH and issue 300 ignored write_in strobes -> drop_cnt_out saturates at 255 and does not wrap.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared state encoding and default sizing for the serial-to-parallel front end.
package deser_pkg;

  typedef enum logic [0:0] {
    RECEIVE,
    PUSH
  } deser_state_t;

  localparam int         WIDTH_DEF = 8;
  localparam int         DEPTH_DEF = 8;
  localparam logic [7:0] DROP_MAX  = 8'hFF;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel front end for the byte queue: assembles MSB-first words,
// pushes each one with a single-cycle enqueue pulse and stalls while the queue is full.
module deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = 4
) (
  input  logic             clock_10,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic [LEN_W-1:0] queue_len_in,
  output logic [WIDTH-1:0] data_out,
  output logic             enq_out,
  output logic             status_out,
  output logic [7:0]       drop_cnt_out
);

  localparam int               CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam logic [LEN_W-1:0] FULL_LEVEL = LEN_W'(DEPTH);

  deser_state_t     state;
  deser_state_t     state_next;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_next;
  logic [WIDTH-1:0] data_next;
  logic             enq_next;
  logic             status_next;
  logic [7:0]       drop_next;
  logic             queue_has_room;

  // Anything at or above DEPTH, including illegal occupancies, counts as full.
  assign queue_has_room = (queue_len_in < FULL_LEVEL);

  always_ff @(posedge clock_10 or posedge reset) begin
    if (reset) begin
      state        <= RECEIVE;
      shift_q      <= '0;
      bit_cnt      <= '0;
      data_out     <= '0;
      enq_out      <= 1'b0;
      status_out   <= 1'b1;
      drop_cnt_out <= '0;
    end else begin
      state        <= state_next;
      shift_q      <= shift_next;
      bit_cnt      <= bit_cnt_next;
      data_out     <= data_next;
      enq_out      <= enq_next;
      status_out   <= status_next;
      drop_cnt_out <= drop_next;
    end
  end

  // Every output is computed here and registered above, so enq_out drops on the
  // edge after it rises regardless of what the queue is doing.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt;
    data_next    = data_out;
    enq_next     = 1'b0;
    status_next  = status_out;
    drop_next    = drop_cnt_out;

    unique case (state)
      RECEIVE: begin
        if (write_in) begin
          shift_next = {shift_q[WIDTH-2:0], data_in};
          if (bit_cnt == LAST_BIT) begin
            data_next    = shift_next;
            bit_cnt_next = '0;
            state_next   = PUSH;
            status_next  = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end
      end

      PUSH: begin
        if (write_in && (drop_cnt_out != DROP_MAX)) begin
          drop_next = drop_cnt_out + 8'd1;
        end
        if (queue_has_room) begin
          enq_next    = 1'b1;
          state_next  = RECEIVE;
          status_next = 1'b1;
        end
      end

      default: begin
        state_next = RECEIVE;
      end
    endcase
  end

endmodule

// File: tb/tb_deserializer.sv
// Randomized self-checking bench for deserializer against a bit-queue reference
// model, with a behavioural byte queue closing the occupancy loop.
`timescale 1us / 1ns

module tb_deserializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int LEN_W = 4;

  logic             clock_10;
  logic             reset;
  logic             data_in;
  logic             write_in;
  logic [LEN_W-1:0] queue_len_in;
  logic [WIDTH-1:0] data_out;
  logic             enq_out;
  logic             status_out;
  logic [7:0]       drop_cnt_out;

  deserializer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .LEN_W(LEN_W)
  ) dut (
    .clock_10    (clock_10),
    .reset       (reset),
    .data_in     (data_in),
    .write_in    (write_in),
    .queue_len_in(queue_len_in),
    .data_out    (data_out),
    .enq_out     (enq_out),
    .status_out  (status_out),
    .drop_cnt_out(drop_cnt_out)
  );

  initial clock_10 = 1'b0;
  always #50 clock_10 = ~clock_10;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits collected so far, pending word, expected outputs.
  logic             bitq[$];
  logic             m_push;
  logic [WIDTH-1:0] exp_data;
  logic             exp_enq;
  int               exp_drops;

  // Behavioural byte queue fed by the DUT; qlen_force >= 0 overrides its occupancy.
  logic [7:0] fifo[$];
  int         qlen_force = -1;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] pack_bits();
    logic [WIDTH-1:0] val = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bitq[i]) val = val + (WIDTH'(1) << (WIDTH - 1 - i));
    end
    return val;
  endfunction

  task automatic model_reset();
    bitq.delete();
    m_push    = 1'b0;
    exp_data  = '0;
    exp_enq   = 1'b0;
    exp_drops = 0;
  endtask

  task automatic model_step(input logic w, input logic d, input int qlen);
    exp_enq = 1'b0;
    if (m_push) begin
      if (w) exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
      if (qlen < DEPTH) begin
        exp_enq = 1'b1;
        m_push  = 1'b0;
      end
    end else if (w) begin
      bitq.push_back(d);
      if (bitq.size() == WIDTH) begin
        exp_data = pack_bits();
        bitq.delete();
        m_push = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check_output("data_out", 32'(data_out), 32'(exp_data));
    check_output("enq_out", 32'(enq_out), 32'(exp_enq));
    check_output("status_out", 32'(status_out), 32'(!m_push));
    check_output("drop_cnt_out", 32'(drop_cnt_out), 32'(exp_drops));
  endtask

  // One clock: drive inputs, let the queue capture on enq_out, advance the model, compare.
  task automatic apply_stimulus(input logic w, input logic d);
    logic             pre_enq;
    logic [WIDTH-1:0] pre_data;
    logic [LEN_W-1:0] qlen;
    write_in = w;
    data_in  = d;
    qlen = (qlen_force >= 0) ? LEN_W'(qlen_force) : LEN_W'(fifo.size());
    queue_len_in = qlen;
    pre_enq  = enq_out;
    pre_data = data_out;
    @(posedge clock_10);
    model_step(w, d, int'(qlen));
    if (pre_enq) begin
      if (qlen_force < 0) check_output("queue_room", 32'(fifo.size() < DEPTH), 32'd1);
      fifo.push_back(pre_data);
    end
    #1;
    compare_all();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (m_push && n < 50) begin
      apply_stimulus(1'b0, 1'b0);
      n++;
    end
    if (m_push) check_output("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic gapped);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      wait_ready();
      apply_stimulus(1'b1, b[i]);
      if (gapped) apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Asynchronous reset asserted between edges and held across one edge.
  task automatic do_reset();
    #5;
    write_in = 1'b1;
    data_in  = 1'($urandom_range(0, 1));
    reset    = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clock_10);
    #1;
    compare_all();
    #5;
    reset    = 1'b0;
    write_in = 1'b0;
  endtask

  initial begin
    logic [7:0] popped;
    reset        = 1'b0;
    write_in     = 1'b0;
    data_in      = 1'b0;
    queue_len_in = '0;
    model_reset();
    #3;
    reset = 1'b1;
    #1;
    compare_all();
    @(posedge clock_10);
    #1;
    reset = 1'b0;

    $display("[TB] contiguous byte A5");
    send_byte(8'hA5, 1'b0);
    check_output("a5_data", 32'(data_out), 32'hA5);
    check_output("a5_stalled", 32'(status_out), 32'd0);
    idle(1);
    check_output("a5_enq", 32'(enq_out), 32'd1);
    idle(2);

    $display("[TB] gapped byte 3C");
    send_byte(8'h3C, 1'b1);
    idle(3);
    check_output("3c_data", 32'(data_out), 32'h3C);

    $display("[TB] full queue stall");
    qlen_force = DEPTH;
    send_byte(8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
    idle(2);
    check_output("stall_drops", 32'(drop_cnt_out), 32'd3);
    check_output("stall_data", 32'(data_out), 32'hFF);
    check_output("stall_no_enq", 32'(enq_out), 32'd0);
    qlen_force = DEPTH - 1;
    idle(1);
    check_output("unstall_enq", 32'(enq_out), 32'd1);
    check_output("unstall_status", 32'(status_out), 32'd1);
    idle(2);

    $display("[TB] stream nine bytes into queue");
    qlen_force = -1;
    fifo.delete();
    for (int b = 1; b <= 9; b++) send_byte(8'(b), 1'b0);
    idle(3);
    check_output("q_len_full", 32'(fifo.size()), 32'd8);
    check_output("q_ninth_stalled", 32'(status_out), 32'd0);
    popped = fifo.pop_front();
    check_output("q_first_out", 32'(popped), 32'h01);
    idle(2);
    check_output("q_len_refill", 32'(fifo.size()), 32'd8);
    check_output("q_last_byte", 32'(fifo[fifo.size() - 1]), 32'h09);

    $display("[TB] reset mid-byte and mid-stall");
    fifo.delete();
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'($urandom_range(0, 1)));
    do_reset();
    qlen_force = DEPTH;
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    idle(2);
    do_reset();
    qlen_force = -1;
    send_byte(8'h5A, 1'b0);
    check_output("5a_data", 32'(data_out), 32'h5A);
    idle(3);

    $display("[TB] drop counter saturation");
    qlen_force = $urandom_range(DEPTH, 15);
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 300; i++) apply_stimulus(1'b1, 1'($urandom_range(0, 1)));
    check_output("drop_saturated", 32'(drop_cnt_out), 32'd255);
    qlen_force = -1;
    fifo.delete();
    idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      if (fifo.size() > 0 && $urandom_range(0, 3) == 0) popped = fifo.pop_front();
      apply_stimulus(1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
